// File: rtl/morse_timing_calibrator_pkg.sv
// morse_timing_calibrator_pkg: shared widths, FSM state encoding and saturation helper
package morse_timing_calibrator_pkg;

    localparam int PULSE_CNT_W = 16;
    localparam int CAL_XW      = PULSE_CNT_W + 3;

    typedef enum logic [1:0] {
        CAL_WAIT_LOW,
        CAL_IDLE,
        CAL_MARK,
        CAL_EVAL
    } cal_state_t;

    function automatic logic [PULSE_CNT_W-1:0] sat_w(input logic [CAL_XW-1:0] v);
        return (|v[CAL_XW-1:PULSE_CNT_W]) ? '1 : v[PULSE_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/morse_timing_calibrator.sv
// morse_timing_calibrator: measures mark lengths and adapts the dit estimate driving decoder timing
module morse_timing_calibrator
    import morse_timing_calibrator_pkg::*;
#(
    parameter int INIT_DIT  = 10,
    parameter int MIN_PULSE = 2,
    parameter int LOCK_CNT  = 4,
    parameter int SHORT_MAX = 3
) (
    input  logic                   clk,
    input  logic                   aclr_n,
    input  logic                   ce,
    input  logic                   signal,
    output logic [PULSE_CNT_W-1:0] dit_time,
    output logic [PULSE_CNT_W-1:0] dah_time,
    output logic [PULSE_CNT_W-1:0] word_time,
    output logic [PULSE_CNT_W-1:0] tol_time,
    output logic                   locked,
    output logic                   upd,
    output logic                   outlier
);

    localparam int W  = PULSE_CNT_W;
    localparam int XW = CAL_XW;
    localparam int HW = $clog2(LOCK_CNT + 1);
    localparam int SW = $clog2(SHORT_MAX + 1);

    cal_state_t    state, state_nxt;
    logic [W-1:0]  len, len_nxt, dit, dit_nxt;
    logic [HW-1:0] hit, hit_nxt;
    logic [SW-1:0] short_cnt, short_nxt;
    logic          locked_nxt, upd_nxt, outlier_nxt;
    logic [XW-1:0] dx, lx, half, two, five, avg;

    assign dx        = {3'b000, dit};
    assign lx        = {3'b000, len};
    assign half      = dx >> 1;
    assign two       = dx << 1;
    assign five      = (dx << 2) + dx;
    assign avg       = ((dx << 1) + dx + lx) >> 2;
    assign dit_time  = dit;
    assign dah_time  = sat_w((dx << 1) + dx);
    assign word_time = sat_w((dx << 3) - dx);
    assign tol_time  = dit >> 1;

    // State, measurement and estimate registers; everything derived follows dit in the same clk
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state     <= CAL_WAIT_LOW;
            len       <= '0;
            dit       <= W'(INIT_DIT);
            hit       <= '0;
            short_cnt <= '0;
            locked    <= 1'b0;
            upd       <= 1'b0;
            outlier   <= 1'b0;
        end else begin
            state     <= state_nxt;
            len       <= len_nxt;
            dit       <= dit_nxt;
            hit       <= hit_nxt;
            short_cnt <= short_nxt;
            locked    <= locked_nxt;
            upd       <= upd_nxt;
            outlier   <= outlier_nxt;
        end
    end

    // Mark capture FSM and one-clock classification of the finished mark
    always_comb begin
        state_nxt   = state;
        len_nxt     = len;
        dit_nxt     = dit;
        hit_nxt     = hit;
        short_nxt   = short_cnt;
        locked_nxt  = locked;
        upd_nxt     = 1'b0;
        outlier_nxt = 1'b0;
        case (state)
            CAL_WAIT_LOW: if (ce && !signal) state_nxt = CAL_IDLE;
            CAL_IDLE: if (ce && signal) begin
                state_nxt = CAL_MARK;
                len_nxt   = W'(1);
            end
            CAL_MARK: if (ce) begin
                if (signal) len_nxt = (&len) ? len : len + 1'b1;
                else state_nxt = CAL_EVAL;
            end
            CAL_EVAL: begin
                state_nxt = CAL_IDLE;
                if (lx < XW'(MIN_PULSE)) begin
                end else if ((&len) || lx > five) begin
                    outlier_nxt = 1'b1;
                    short_nxt   = '0;
                    hit_nxt     = '0;
                    locked_nxt  = 1'b0;
                end else if (lx > two) begin
                    upd_nxt   = 1'b1;
                    short_nxt = '0;
                end else if (lx >= half) begin
                    dit_nxt   = (avg == '0) ? W'(1) : sat_w(avg);
                    short_nxt = '0;
                    hit_nxt   = (hit == HW'(LOCK_CNT)) ? hit : hit + 1'b1;
                    if (hit_nxt == HW'(LOCK_CNT)) locked_nxt = 1'b1;
                    upd_nxt   = 1'b1;
                end else if (short_cnt == SW'(SHORT_MAX - 1)) begin
                    dit_nxt    = len;
                    locked_nxt = 1'b0;
                    short_nxt  = '0;
                    hit_nxt    = '0;
                    upd_nxt    = 1'b1;
                end else begin
                    short_nxt = short_cnt + 1'b1;
                    hit_nxt   = '0;
                end
            end
            default: state_nxt = CAL_WAIT_LOW;
        endcase
    end

endmodule

// File: tb/tb_morse_timing_calibrator.sv
// tb_morse_timing_calibrator: table-driven mark sequences plus reset, ce and saturation corner cases
module tb_morse_timing_calibrator;
    import morse_timing_calibrator_pkg::*;

    localparam int W = PULSE_CNT_W;

    logic         clk = 1'b0, aclr_n = 1'b0, ce = 1'b1, signal = 1'b0;
    logic [W-1:0] dit_a, dah_a, word_a, tol_a, dit_b, dah_b, word_b, tol_b;
    logic         locked_a, upd_a, outlier_a, locked_b, upd_b, outlier_b;
    int           checks = 0, errors = 0;

    typedef struct {
        int   len;
        int   dit;
        logic upd;
        logic outl;
        logic lk;
    } vec_t;

    vec_t vt[20];

    morse_timing_calibrator #(.INIT_DIT(10)) dut (
        .clk(clk), .aclr_n(aclr_n), .ce(ce), .signal(signal),
        .dit_time(dit_a), .dah_time(dah_a), .word_time(word_a), .tol_time(tol_a),
        .locked(locked_a), .upd(upd_a), .outlier(outlier_a)
    );

    morse_timing_calibrator #(.INIT_DIT(10000)) dut_big (
        .clk(clk), .aclr_n(aclr_n), .ce(ce), .signal(signal),
        .dit_time(dit_b), .dah_time(dah_b), .word_time(word_b), .tol_time(tol_b),
        .locked(locked_b), .upd(upd_b), .outlier(outlier_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat16(input int v);
        return v > 65535 ? 65535 : v;
    endfunction

    task automatic check_timing(input string tag, input int d);
        chk({tag, " dit"}, dit_a, d);
        chk({tag, " dah"}, dah_a, sat16(3 * d));
        chk({tag, " word"}, word_a, sat16(7 * d));
        chk({tag, " tol"}, tol_a, d / 2);
    endtask

    task automatic run(input int n, output int nu, output int no);
        nu = 0;
        no = 0;
        repeat (n) begin
            @(negedge clk);
            nu += int'(upd_a);
            no += int'(outlier_a);
        end
    endtask

    task automatic mark(input int n);
        signal = 1'b1;
        repeat (n) @(negedge clk);
        signal = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int nu, no, nu2, no2;
        vt[0]  = '{14, 11, 1'b1, 1'b0, 1'b0};
        vt[1]  = '{14, 11, 1'b1, 1'b0, 1'b0};
        vt[2]  = '{14, 11, 1'b1, 1'b0, 1'b0};
        vt[3]  = '{14, 11, 1'b1, 1'b0, 1'b1};
        vt[4]  = '{30, 11, 1'b1, 1'b0, 1'b1};
        vt[5]  = '{1,  11, 1'b0, 1'b0, 1'b1};
        vt[6]  = '{22, 13, 1'b1, 1'b0, 1'b1};
        vt[7]  = '{27, 13, 1'b1, 1'b0, 1'b1};
        vt[8]  = '{65, 13, 1'b1, 1'b0, 1'b1};
        vt[9]  = '{66, 13, 1'b0, 1'b1, 1'b0};
        vt[10] = '{6,  11, 1'b1, 1'b0, 1'b0};
        vt[11] = '{4,  11, 1'b0, 1'b0, 1'b0};
        vt[12] = '{4,  11, 1'b0, 1'b0, 1'b0};
        vt[13] = '{14, 11, 1'b1, 1'b0, 1'b0};
        vt[14] = '{4,  11, 1'b0, 1'b0, 1'b0};
        vt[15] = '{4,  11, 1'b0, 1'b0, 1'b0};
        vt[16] = '{4,  4,  1'b1, 1'b0, 1'b0};
        vt[17] = '{2,  3,  1'b1, 1'b0, 1'b0};
        vt[18] = '{2,  2,  1'b1, 1'b0, 1'b0};
        vt[19] = '{1,  2,  1'b0, 1'b0, 1'b0};

        signal = 1'b1;
        repeat (3) @(negedge clk);
        check_timing("reset", 10);
        chk("reset locked", locked_a, 0);
        chk("reset upd", upd_a, 0);
        chk("reset outlier", outlier_a, 0);
        chk("big dit", dit_b, 10000);
        chk("big dah", dah_b, 30000);
        chk("big word sat", word_b, 65535);
        chk("big tol", tol_b, 5000);
        chk("big flags", {locked_b, upd_b, outlier_b}, 0);

        aclr_n = 1'b1;
        run(20, nu, no);
        signal = 1'b0;
        run(5, nu2, no2);
        chk("held mark upd", nu + nu2, 0);
        chk("held mark outlier", no + no2, 0);
        check_timing("held mark", 10);

        for (int i = 0; i < 20; i++) begin
            string tag;
            tag = $sformatf("row%0d", i);
            mark(vt[i].len);
            chk({tag, " upd"}, upd_a, vt[i].upd);
            chk({tag, " outlier"}, outlier_a, vt[i].outl);
            chk({tag, " locked"}, locked_a, vt[i].lk);
            check_timing(tag, vt[i].dit);
        end

        run(3, nu, no);
        chk("strobe clear upd", nu, 0);
        chk("strobe clear outlier", no, 0);

        signal = 1'b1;
        repeat (6) @(negedge clk);
        #2 aclr_n = 1'b0;
        @(negedge clk);
        check_timing("midmark reset", 10);
        chk("midmark locked", locked_a, 0);
        aclr_n = 1'b1;
        run(8, nu, no);
        signal = 1'b0;
        run(5, nu2, no2);
        chk("midmark remainder upd", nu + nu2, 0);
        check_timing("midmark remainder", 10);

        signal = 1'b1;
        repeat (7) @(negedge clk);
        ce = 1'b0;
        repeat (4) @(negedge clk);
        ce = 1'b1;
        repeat (7) @(negedge clk);
        signal = 1'b0;
        @(negedge clk);
        ce = 1'b0;
        @(negedge clk);
        chk("ce gated upd", upd_a, 1);
        check_timing("ce gated", 11);
        ce = 1'b1;
        run(2, nu, no);
        chk("ce gated strobe clear", nu, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
